// File: rtl/elev_sched_pkg.sv
// Shared types and defaults for the elevator request scheduler.
// The EMERG state exists only when ELEV_SCHED_EMERGENCY_EN is defined.
package elev_sched_pkg;

   localparam int NUM_FLOORS = 8;
   localparam int FLOOR_W    = 3;
   localparam int ONEHOT_MAX = 64;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SERVE_UP   = 3'd1,
      SERVE_DOWN = 3'd2,
`ifdef ELEV_SCHED_EMERGENCY_EN
      DWELL      = 3'd3,
      EMERG      = 3'd4
`else
      DWELL      = 3'd3
`endif
   } state_t;

   // Callers truncate the result to their floor count, so out-of-range indices select nothing.
   function automatic logic [ONEHOT_MAX-1:0] floor_onehot(input int unsigned idx);
      floor_onehot = {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/elevator_request_scheduler_if.sv
// Button/position inputs and target/status outputs between the controller side and the scheduler.
// The emerg line is present only when ELEV_SCHED_EMERGENCY_EN is defined.
interface elevator_request_scheduler_if #(
   parameter int NUM_FLOORS = elev_sched_pkg::NUM_FLOORS,
   parameter int FLOOR_W    = elev_sched_pkg::FLOOR_W
);
   logic [NUM_FLOORS-1:0] btn;
   logic [FLOOR_W-1:0]    curr_floor;
   logic                  door;
`ifdef ELEV_SCHED_EMERGENCY_EN
   logic                  emerg;
`endif
   logic [FLOOR_W-1:0]    req_floor;
   logic [NUM_FLOORS-1:0] pending;
   logic                  dir_up;
   logic                  busy;

`ifdef ELEV_SCHED_EMERGENCY_EN
   modport master (output btn, curr_floor, door, emerg, input req_floor, pending, dir_up, busy);
   modport slave  (input btn, curr_floor, door, emerg, output req_floor, pending, dir_up, busy);
`else
   modport master (output btn, curr_floor, door, input req_floor, pending, dir_up, busy);
   modport slave  (input btn, curr_floor, door, output req_floor, pending, dir_up, busy);
`endif
endinterface

// File: rtl/elev_floor_picker.sv
// Combinational search of the pending bitmap relative to the car position:
// nearest call above/below and which direction is closer.
module elev_floor_picker #(
   parameter int NUM_FLOORS = elev_sched_pkg::NUM_FLOORS,
   parameter int FLOOR_W    = elev_sched_pkg::FLOOR_W
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]    curr_floor,
   output logic                  above,
   output logic                  below,
   output logic [FLOOR_W-1:0]    next_up,
   output logic [FLOOR_W-1:0]    next_dn,
   output logic                  tie,
   output logic                  up_closer
);
   logic [FLOOR_W-1:0] d_up;
   logic [FLOOR_W-1:0] d_dn;

   always_comb begin
      above   = 1'b0;
      below   = 1'b0;
      next_up = '0;
      next_dn = '0;
      // Scanning downward leaves the lowest hit above; scanning upward leaves the highest hit below.
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending[i] && (i > int'(curr_floor))) begin
            above   = 1'b1;
            next_up = FLOOR_W'(i);
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (i < int'(curr_floor))) begin
            below   = 1'b1;
            next_dn = FLOOR_W'(i);
         end
      end
      d_up      = next_up - curr_floor;
      d_dn      = curr_floor - next_dn;
      tie       = above && below && (d_up == d_dn);
      up_closer = above && (!below || (d_up < d_dn));
   end
endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler: pending-call bitmap, sweep FSM, door dwell timer, registered req_floor.
// Optional emergency recall to floor 0 under ELEV_SCHED_EMERGENCY_EN.
module elevator_request_scheduler
   import elev_sched_pkg::*;
#(
   parameter int NUM_FLOORS   = elev_sched_pkg::NUM_FLOORS,
   parameter int FLOOR_W      = elev_sched_pkg::FLOOR_W,
   parameter int DWELL_CYCLES = 4
) (
   input logic                       clk,
   input logic                       rst,
   elevator_request_scheduler_if.slave bus
);
   localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

   state_t                state, state_nxt;
   logic [NUM_FLOORS-1:0] pending_q, pending_nxt, curr_oh, clr;
   logic [FLOOR_W-1:0]    req_q, req_nxt;
   logic                  dir_q, dir_nxt;
   logic                  busy_q, busy_nxt;
   logic [CNT_W-1:0]      cnt_q, cnt_nxt;

   logic                  above, below, tie, up_closer;
   logic [FLOOR_W-1:0]    next_up, next_dn;
   logic                  arrival, at_call, dwell_done, go_up;

   elev_floor_picker #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_picker (
      .pending    (pending_q),
      .curr_floor (bus.curr_floor),
      .above      (above),
      .below      (below),
      .next_up    (next_up),
      .next_dn    (next_dn),
      .tie        (tie),
      .up_closer  (up_closer)
   );

   assign curr_oh    = NUM_FLOORS'(floor_onehot(32'(bus.curr_floor)));
   assign arrival    = bus.door && (bus.curr_floor == req_q) &&
                       ((state == SERVE_UP) || (state == SERVE_DOWN));
   assign at_call    = |(pending_q & curr_oh);
   assign dwell_done = (cnt_q == CNT_LAST);
   assign go_up      = up_closer || tie;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (at_call)    state_nxt = DWELL;
            else if (go_up) state_nxt = SERVE_UP;
            else if (below) state_nxt = SERVE_DOWN;
         end
         SERVE_UP: begin
            if (arrival)              state_nxt = DWELL;
            else if (!above && below) state_nxt = SERVE_DOWN;
         end
         SERVE_DOWN: begin
            if (arrival)              state_nxt = DWELL;
            else if (!below && above) state_nxt = SERVE_UP;
         end
         DWELL: begin
            // Keep sweeping while calls lie ahead; only then consider reversing.
            if (dwell_done) begin
               if (dir_q ? above : below)      state_nxt = dir_q ? SERVE_UP : SERVE_DOWN;
               else if (dir_q ? below : above) state_nxt = dir_q ? SERVE_DOWN : SERVE_UP;
               else                            state_nxt = IDLE;
            end
         end
`ifdef ELEV_SCHED_EMERGENCY_EN
         EMERG: begin
            if (!bus.emerg && (bus.curr_floor == '0) && bus.door) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
`ifdef ELEV_SCHED_EMERGENCY_EN
      if (bus.emerg) state_nxt = EMERG;
`endif
   end

   always_comb begin
      clr         = (arrival || (state == DWELL)) ? curr_oh : '0;
      pending_nxt = (pending_q | bus.btn) & ~clr;
`ifdef ELEV_SCHED_EMERGENCY_EN
      if (bus.emerg || (state == EMERG)) pending_nxt = '0;
`endif
      case (state_nxt)
         SERVE_UP:   req_nxt = above ? next_up : req_q;
         SERVE_DOWN: req_nxt = below ? next_dn : req_q;
`ifdef ELEV_SCHED_EMERGENCY_EN
         EMERG:      req_nxt = '0;
`endif
         default:    req_nxt = bus.curr_floor;
      endcase
      dir_nxt = dir_q;
      if (state_nxt == SERVE_UP)   dir_nxt = 1'b1;
      if (state_nxt == SERVE_DOWN) dir_nxt = 1'b0;
`ifdef ELEV_SCHED_EMERGENCY_EN
      if ((state == EMERG) && (state_nxt == IDLE)) dir_nxt = 1'b1;
`endif
      busy_nxt = (|pending_nxt) || (state_nxt == DWELL);
      cnt_nxt  = ((state == DWELL) && (state_nxt == DWELL)) ? cnt_q + 1'b1 : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         req_q     <= '0;
         dir_q     <= 1'b1;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         pending_q <= pending_nxt;
         req_q     <= req_nxt;
         dir_q     <= dir_nxt;
         busy_q    <= busy_nxt;
         cnt_q     <= cnt_nxt;
      end
   end

   assign bus.pending   = pending_q;
   assign bus.req_floor = req_q;
   assign bus.dir_up    = dir_q;
   assign bus.busy      = busy_q;
endmodule
